// File: rtl/ptw_pte_writer_pkg.sv
// Shared types for the page-table-walker PTE writer.
// PTE bundle, Sv32 layout constants and writer FSM states.
package ptw_pte_writer_pkg;

  localparam int PTE_BYTES     = 4;
  localparam int SV32_PPN_BITS = 22;
  localparam int PTE_PPN_BITS  = 54;

  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_flags_t;

  typedef struct packed {
    logic [PTE_PPN_BITS-1:0] ppn;
    pte_flags_t              f;
  } pte_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/ptw_pte_writer_pte_pack.sv
// Packs an unpacked PTE into the 32-bit Sv32 word.
// Also flags ppn bits that do not fit in Sv32.
module pte_pack
  import ptw_pte_writer_pkg::*;
#(
  parameter int PPN_BITS = 54
) (
  input  logic [PPN_BITS-1:0] i_ppn,
  input  pte_flags_t          i_flags,
  output logic [31:0]         o_word,
  output logic                o_ppn_ovf
);

  // Sv32 layout: ppn[21:0], two RSW bits, then flag byte
  assign o_word = {i_ppn[SV32_PPN_BITS-1:0], 2'b00, i_flags};

  // Any ppn bit above the Sv32 field makes the entry invalid
  assign o_ppn_ovf = |i_ppn[PPN_BITS-1:SV32_PPN_BITS];

endmodule

// File: rtl/ptw_pte_writer.sv
// Sets A/D bits of a PTE and writes it back to memory.
// One request in flight; all outputs are registered.
module ptw_pte_writer
  import ptw_pte_writer_pkg::*;
#(
  parameter int PADDR_BITS = 34,
  parameter int PPN_BITS   = 54
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PADDR_BITS-1:0] req_addr,
  input  logic                  req_store,
  input  logic [PPN_BITS-1:0]   req_pte_ppn,
  input  logic                  req_pte_d,
  input  logic                  req_pte_a,
  input  logic                  req_pte_g,
  input  logic                  req_pte_u,
  input  logic                  req_pte_x,
  input  logic                  req_pte_w,
  input  logic                  req_pte_r,
  input  logic                  req_pte_v,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PADDR_BITS-1:0] mem_req_addr,
  output logic [31:0]           mem_req_data,
  input  logic                  mem_resp_valid,
  input  logic                  mem_resp_error,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_fault,
  output logic [PPN_BITS-1:0]   resp_pte_ppn,
  output logic                  resp_pte_d,
  output logic                  resp_pte_a,
  output logic                  resp_pte_g,
  output logic                  resp_pte_u,
  output logic                  resp_pte_x,
  output logic                  resp_pte_w,
  output logic                  resp_pte_r,
  output logic                  resp_pte_v
);

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_mem_valid;
  logic [PADDR_BITS-1:0] r_mem_addr;
  logic [31:0]           r_mem_data;
  logic                  r_resp_valid;
  logic                  r_resp_fault;
  logic [PPN_BITS-1:0]   r_resp_ppn;
  pte_flags_t            r_resp_flags;

  pte_flags_t  w_in_flags;
  pte_flags_t  w_upd_flags;
  logic [31:0] w_word;
  logic        w_ovf;
  logic        w_fault;
  logic        w_skip;

  // Gather request flags and apply the A/D update
  always_comb begin
    w_in_flags   = '0;
    w_in_flags.d = req_pte_d;
    w_in_flags.a = req_pte_a;
    w_in_flags.g = req_pte_g;
    w_in_flags.u = req_pte_u;
    w_in_flags.x = req_pte_x;
    w_in_flags.w = req_pte_w;
    w_in_flags.r = req_pte_r;
    w_in_flags.v = req_pte_v;
    w_upd_flags   = w_in_flags;
    w_upd_flags.a = 1'b1;
    w_upd_flags.d = req_pte_d | req_store;
  end

  pte_pack #(
    .PPN_BITS (PPN_BITS)
  ) u_pack (
    .i_ppn     (req_pte_ppn),
    .i_flags   (w_upd_flags),
    .o_word    (w_word),
    .o_ppn_ovf (w_ovf)
  );

  assign w_fault = !req_pte_v
                 | (req_pte_w & !req_pte_r)
                 | (req_store & !req_pte_w)
                 | w_ovf;

  // Already accessed, and dirty unless this is a load
  assign w_skip = req_pte_a & (req_pte_d | !req_store);

  // Writer FSM with registered handshake and result outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_ppn   <= '0;
      r_resp_flags <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_mem_addr  <= req_addr;
            r_mem_data  <= w_word;
            r_resp_ppn  <= req_pte_ppn;
            if (w_fault) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_flags <= w_in_flags;
            end else if (w_skip) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b0;
              r_resp_flags <= w_upd_flags;
            end else begin
              r_state      <= S_WRITE;
              r_mem_valid  <= 1'b1;
              r_resp_flags <= w_upd_flags;
            end
          end
        end
        S_WRITE: begin
          if (mem_req_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= mem_resp_error;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign mem_req_valid = r_mem_valid;
  assign mem_req_addr  = r_mem_addr;
  assign mem_req_data  = r_mem_data;
  assign resp_valid    = r_resp_valid;
  assign resp_fault    = r_resp_fault;
  assign resp_pte_ppn  = r_resp_ppn;
  assign resp_pte_d    = r_resp_flags.d;
  assign resp_pte_a    = r_resp_flags.a;
  assign resp_pte_g    = r_resp_flags.g;
  assign resp_pte_u    = r_resp_flags.u;
  assign resp_pte_x    = r_resp_flags.x;
  assign resp_pte_w    = r_resp_flags.w;
  assign resp_pte_r    = r_resp_flags.r;
  assign resp_pte_v    = r_resp_flags.v;

endmodule

// File: tb/tb_ptw_pte_writer.sv
// Directed self-checking bench for ptw_pte_writer.
// Drives and samples 1ns after each rising edge.
module tb_ptw_pte_writer;

  localparam int PA = 34;
  localparam int PP = 54;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [PA-1:0] req_addr;
  logic          req_store;
  logic [PP-1:0] req_pte_ppn;
  logic [7:0]    req_flags;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [PA-1:0] mem_req_addr;
  logic [31:0]   mem_req_data;
  logic          mem_resp_valid;
  logic          mem_resp_error;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_fault;
  logic [PP-1:0] resp_pte_ppn;
  logic          rd, ra, rg, ru, rx, rw, rr, rv;
  logic [7:0]    resp_flags;

  int checks = 0;
  int errors = 0;

  logic [7:0]  f_flags [4];
  logic        f_store [4];
  logic [PP-1:0] f_ppn [4];

  always #5 clock = ~clock;

  assign resp_flags = {rd, ra, rg, ru, rx, rw, rr, rv};

  ptw_pte_writer #(
    .PADDR_BITS (PA),
    .PPN_BITS   (PP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_store      (req_store),
    .req_pte_ppn    (req_pte_ppn),
    .req_pte_d      (req_flags[7]),
    .req_pte_a      (req_flags[6]),
    .req_pte_g      (req_flags[5]),
    .req_pte_u      (req_flags[4]),
    .req_pte_x      (req_flags[3]),
    .req_pte_w      (req_flags[2]),
    .req_pte_r      (req_flags[1]),
    .req_pte_v      (req_flags[0]),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_error (mem_resp_error),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_fault     (resp_fault),
    .resp_pte_ppn   (resp_pte_ppn),
    .resp_pte_d     (rd),
    .resp_pte_a     (ra),
    .resp_pte_g     (rg),
    .resp_pte_u     (ru),
    .resp_pte_x     (rx),
    .resp_pte_w     (rw),
    .resp_pte_r     (rr),
    .resp_pte_v     (rv)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [PA-1:0] a,
                       input logic s,
                       input logic [PP-1:0] p,
                       input logic [7:0] f);
    req_addr    = a;
    req_store   = s;
    req_pte_ppn = p;
    req_flags   = f;
    req_valid   = 1'b1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
  endtask

  task automatic reset_outs(input string tag);
    idle_outs(tag);
    chk({tag, "_fault"}, 64'(resp_fault), 64'd0);
    chk({tag, "_ppn"}, 64'(resp_pte_ppn), 64'd0);
    chk({tag, "_flags"}, 64'(resp_flags), 64'd0);
    chk({tag, "_maddr"}, 64'(mem_req_addr), 64'd0);
    chk({tag, "_mdata"}, 64'(mem_req_data), 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_store      = 1'b0;
    req_pte_ppn    = '0;
    req_flags      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
    resp_ready     = 1'b0;

    f_flags[0] = 8'h06; f_store[0] = 1'b0; f_ppn[0] = 54'h12345;
    f_flags[1] = 8'h05; f_store[1] = 1'b0; f_ppn[1] = 54'h12345;
    f_flags[2] = 8'h03; f_store[2] = 1'b1; f_ppn[2] = 54'h12345;
    f_flags[3] = 8'h03; f_store[3] = 1'b0; f_ppn[3] = 54'h400000;

    tick();
    tick();
    reset_outs("rst");
    reset = 1'b0;
    tick();

    // store to a fresh entry: one write, A and D set
    offer(34'h0_8000_1000, 1'b1, 54'h12345, 8'h07);
    tick();
    req_valid = 1'b0;
    chk("w1_req_ready", 64'(req_ready), 64'd0);
    chk("w1_mem_valid", 64'(mem_req_valid), 64'd1);
    chk("w1_maddr", 64'(mem_req_addr), 64'h8000_1000);
    chk("w1_mdata", 64'(mem_req_data), 64'h048D_14C7);
    chk("w1_resp_valid", 64'(resp_valid), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("w1_wait_mvalid", 64'(mem_req_valid), 64'd0);
    chk("w1_wait_rvalid", 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("w1_resp_valid", 64'(resp_valid), 64'd1);
    chk("w1_fault", 64'(resp_fault), 64'd0);
    chk("w1_flags", 64'(resp_flags), 64'hC7);
    chk("w1_ppn", 64'(resp_pte_ppn), 64'h12345);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    idle_outs("w1_done");

    // already accessed and dirty: skip the write
    offer(34'h0_8000_1000, 1'b1, 54'h12345, 8'hC7);
    tick();
    req_valid = 1'b0;
    chk("sk_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("sk_resp_valid", 64'(resp_valid), 64'd1);
    chk("sk_fault", 64'(resp_fault), 64'd0);
    chk("sk_flags", 64'(resp_flags), 64'hC7);
    chk("sk_ppn", 64'(resp_pte_ppn), 64'h12345);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    idle_outs("sk_done");

    // permission and ppn-range faults
    for (int i = 0; i < 4; i++) begin
      offer(34'h0_0000_0100, f_store[i], f_ppn[i], f_flags[i]);
      tick();
      req_valid = 1'b0;
      chk($sformatf("f%0d_mem_valid", i), 64'(mem_req_valid), 64'd0);
      chk($sformatf("f%0d_resp_valid", i), 64'(resp_valid), 64'd1);
      chk($sformatf("f%0d_fault", i), 64'(resp_fault), 64'd1);
      chk($sformatf("f%0d_flags", i), 64'(resp_flags), 64'(f_flags[i]));
      chk($sformatf("f%0d_ppn", i), 64'(resp_pte_ppn), 64'(f_ppn[i]));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk($sformatf("f%0d_mem_after", i), 64'(mem_req_valid), 64'd0);
      idle_outs($sformatf("f%0d_done", i));
    end

    // memory stalls the write for three cycles
    offer(34'h0_0000_2040, 1'b0, 54'h2ABCD, 8'h03);
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st%0d_mvalid", c), 64'(mem_req_valid), 64'd1);
      chk($sformatf("st%0d_maddr", c), 64'(mem_req_addr), 64'h2040);
      chk($sformatf("st%0d_mdata", c), 64'(mem_req_data), 64'h0AAF_3443);
      if (c < 2) tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("st_wait_mvalid", 64'(mem_req_valid), 64'd0);
    tick();
    chk("st_wait_rvalid", 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("st_resp_valid", 64'(resp_valid), 64'd1);
    chk("st_fault", 64'(resp_fault), 64'd0);
    chk("st_flags", 64'(resp_flags), 64'h43);
    chk("st_ppn", 64'(resp_pte_ppn), 64'h2ABCD);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    idle_outs("st_done");

    // bus error on the write, and a slow walker
    offer(34'h3_0000_0008, 1'b1, 54'h1, 8'h07);
    tick();
    req_valid = 1'b0;
    chk("er_maddr", 64'(mem_req_addr), 64'h3_0000_0008);
    chk("er_mdata", 64'(mem_req_data), 64'h0000_04C7);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_error = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
    offer(34'h0_0000_0400, 1'b0, 54'h5, 8'h43);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("er%0d_rvalid", c), 64'(resp_valid), 64'd1);
      chk($sformatf("er%0d_fault", c), 64'(resp_fault), 64'd1);
      chk($sformatf("er%0d_flags", c), 64'(resp_flags), 64'hC7);
      chk($sformatf("er%0d_ppn", c), 64'(resp_pte_ppn), 64'h1);
      chk($sformatf("er%0d_req_ready", c), 64'(req_ready), 64'd0);
      if (c < 2) tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    idle_outs("er_done");

    // reset while waiting for the write response
    offer(34'h0_8000_1000, 1'b1, 54'h12345, 8'h07);
    tick();
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw_in_wait", 64'(mem_req_valid), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_outs("rw");
    mem_resp_valid = 1'b1;
    mem_resp_error = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
    idle_outs("rw_ign");

    // a fresh request after the abandoned write
    offer(34'h0_8000_1000, 1'b1, 54'h12345, 8'h07);
    tick();
    req_valid = 1'b0;
    chk("rn_mvalid", 64'(mem_req_valid), 64'd1);
    chk("rn_mdata", 64'(mem_req_data), 64'h048D_14C7);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("rn_rvalid", 64'(resp_valid), 64'd1);
    chk("rn_fault", 64'(resp_fault), 64'd0);
    chk("rn_flags", 64'(resp_flags), 64'hC7);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    idle_outs("rn_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
